// File: rtl/wavetable_voice_sched_if.sv
// rtl/wavetable_voice_sched_if.sv - ROM read port and mixed-sample output bundle of the voice scheduler
interface wavetable_voice_sched_if;
  logic [6:0]  rom_addr_o;
  logic [7:0]  rom_data_i;
  logic [15:0] sample_o;
  logic        sample_valid_o;

  modport master (
    output rom_addr_o,
    output sample_o,
    output sample_valid_o,
    input  rom_data_i
  );

  modport slave (
    input  rom_addr_o,
    input  sample_o,
    input  sample_valid_o,
    output rom_data_i
  );
endinterface

// File: rtl/wavetable_voice_sched.sv
// rtl/wavetable_voice_sched.sv - shares one 128x8 ROM read port among NVOICE wavetable voices and mixes them
// Optional per-voice attenuation input vol_i is built only when VOICE_VOLUME_EN is defined.
module wavetable_voice_sched #(
  parameter int NVOICE  = 4,
  parameter int PHASE_W = 16,
  parameter int ROM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    sample_tick_i,
  input  logic [NVOICE-1:0]       gate_i,
  input  logic [NVOICE*16-1:0]    inc_i,
`ifdef VOICE_VOLUME_EN
  input  logic [NVOICE*2-1:0]     vol_i,
`endif
  wavetable_voice_sched_if.master bus,
  output logic                    busy_o,
  output logic                    overrun_o
);
  localparam int VW = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam int AW = 8 + $clog2(NVOICE);
  localparam int WW = (ROM_LAT > 2) ? $clog2(ROM_LAT - 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_CAPT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [VW-1:0]      vidx;
  logic [VW-1:0]      addr_voice;
  logic [WW-1:0]      wcnt;
  logic [PHASE_W-1:0] phase [NVOICE];
  logic [PHASE_W-1:0] inc_v;
  logic [AW-1:0]      acc;
  logic [7:0]         voice_byte;
  logic               start, last_voice, wait_done;
  logic               start_frame, load_addr, capt_en, done_en;

  assign start      = sample_tick_i & enable_i;
  assign last_voice = (vidx == VW'(NVOICE - 1));
  assign wait_done  = (wcnt == WW'(ROM_LAT - 2));
  assign busy_o     = (state != S_IDLE);

  // The address is registered on entry to ADDR so rom_addr_o is valid during ADDR itself,
  // which puts the ROM data exactly ROM_LAT cycles later at CAPT.
  assign addr_voice = (state == S_IDLE) ? '0 : VW'(vidx + 1'b1);
  assign inc_v      = PHASE_W'(inc_i[vidx*16 +: 16]);

`ifdef VOICE_VOLUME_EN
  assign voice_byte = bus.rom_data_i >> vol_i[vidx*2 +: 2];
`else
  assign voice_byte = bus.rom_data_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = (ROM_LAT > 1) ? S_WAIT : S_CAPT;
      S_WAIT:  if (wait_done) state_nxt = S_CAPT;
      S_CAPT:  state_nxt = last_voice ? S_DONE : S_ADDR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    load_addr   = 1'b0;
    capt_en     = 1'b0;
    done_en     = 1'b0;
    case (state)
      S_IDLE: begin
        start_frame = start;
        load_addr   = start;
      end
      S_CAPT: begin
        capt_en   = 1'b1;
        load_addr = !last_voice;
      end
      S_DONE:  done_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vidx               <= '0;
      wcnt               <= '0;
      acc                <= '0;
      bus.rom_addr_o     <= '0;
      bus.sample_o       <= '0;
      bus.sample_valid_o <= 1'b0;
      overrun_o          <= 1'b0;
      for (int v = 0; v < NVOICE; v++) phase[v] <= '0;
    end else begin
      if (start_frame) vidx <= '0;
      else if (capt_en && !last_voice) vidx <= vidx + 1'b1;

      if (state == S_ADDR) wcnt <= '0;
      else if (state == S_WAIT) wcnt <= wcnt + 1'b1;

      if (load_addr) bus.rom_addr_o <= phase[addr_voice][PHASE_W-1 -: 7];

      if (start_frame) acc <= '0;
      else if (capt_en && gate_i[vidx]) acc <= acc + AW'(voice_byte);

      // An ungated voice parks at phase 0 so re-gating restarts the wave from its beginning.
      if (capt_en) begin
        if (gate_i[vidx]) phase[vidx] <= phase[vidx] + inc_v;
        else              phase[vidx] <= '0;
      end

      bus.sample_valid_o <= done_en;
      if (done_en) bus.sample_o <= 16'(acc);

      if (start && busy_o) overrun_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wavetable_voice_sched.sv
// tb/tb_wavetable_voice_sched.sv - scoreboard bench for wavetable_voice_sched with a 2-cycle ROM model
module tb_wavetable_voice_sched;
  localparam int NV  = 4;
  localparam int LAT = 13;
`ifdef VOICE_VOLUME_EN
  localparam bit VOL_EN = 1'b1;
`else
  localparam bit VOL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable_i = 1'b0;
  logic             sample_tick_i = 1'b0;
  logic [NV-1:0]    gate_i = '0;
  logic [NV*16-1:0] inc_i = '0;
  logic [NV*2-1:0]  vol_i = '0;
  logic             busy_o, overrun_o;

  wavetable_voice_sched_if bus ();

  wavetable_voice_sched #(.NVOICE(NV), .PHASE_W(16), .ROM_LAT(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .sample_tick_i (sample_tick_i),
    .gate_i        (gate_i),
    .inc_i         (inc_i),
`ifdef VOICE_VOLUME_EN
    .vol_i         (vol_i),
`endif
    .bus           (bus.master),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  // ROM model: data = address, or a constant; two register stages give ROM_LAT = 2
  bit         rom_mode = 1'b0;
  logic [7:0] rom_const = 8'h00;
  logic [7:0] rom_p1 = 8'h00, rom_p2 = 8'h00;
  always @(posedge clk) begin
    rom_p1 <= rom_mode ? rom_const : {1'b0, bus.rom_addr_o};
    rom_p2 <= rom_p1;
  end
  assign bus.rom_data_i = rom_p2;

  typedef struct {
    logic [15:0] val;
    int          tcyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0]  rconst;
    logic [3:0]  gate;
    logic [7:0]  vol;
    logic [15:0] exp_plain;
    logic [15:0] exp_vol;
  } vec_t;
  vec_t vecs[6];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nvalid = 0;
  logic [15:0] mphase [NV];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.sample_valid_o) begin
      nvalid++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got sample 0x%0h with nothing expected", bus.sample_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sample", {16'h0, bus.sample_o}, {16'h0, e.val});
        check("latency", cyc - e.tcyc, LAT);
      end
    end
  end

  function automatic logic [15:0] model_frame();
    logic [15:0] s;
    logic [7:0]  b;
    logic [1:0]  sh;
    s = '0;
    for (int v = 0; v < NV; v++) begin
      if (gate_i[v]) begin
        b  = rom_mode ? rom_const : {1'b0, mphase[v][15:9]};
        sh = VOL_EN ? vol_i[v*2 +: 2] : 2'd0;
        s  = s + 16'(b >> sh);
        mphase[v] = mphase[v] + inc_i[v*16 +: 16];
      end else begin
        mphase[v] = '0;
      end
    end
    return s;
  endfunction

  task automatic tick(input bit push, input logic [15:0] val);
    exp_t e;
    @(negedge clk);
    sample_tick_i = 1'b1;
    if (push) begin
      e.val  = val;
      e.tcyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    sample_tick_i = 1'b0;
  endtask

  task automatic model_tick();
    logic [15:0] v;
    v = model_frame();
    tick(1'b1, v);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d samples still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int v = 0; v < NV; v++) mphase[v] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;

    vecs[0] = '{8'hFF, 4'b1111, 8'h00, 16'h03FC, 16'h03FC};
    vecs[1] = '{8'hFF, 4'b0101, 8'h00, 16'h01FE, 16'h01FE};
    vecs[2] = '{8'h80, 4'b0001, 8'h02, 16'h0080, 16'h0020};
    vecs[3] = '{8'h10, 4'b1010, 8'hC4, 16'h0020, 16'h000A};
    vecs[4] = '{8'h00, 4'b1111, 8'hFF, 16'h0000, 16'h0000};
    vecs[5] = '{8'h7F, 4'b1000, 8'h00, 16'h007F, 16'h007F};

    for (int v = 0; v < NV; v++) mphase[v] = '0;
    do_reset();
    enable_i = 1'b1;
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_overrun", {31'h0, overrun_o}, 32'h0);
    check("rst_valid", {31'h0, bus.sample_valid_o}, 32'h0);
    check("rst_sample", {16'h0, bus.sample_o}, 32'h0);
    check("rst_addr", {25'h0, bus.rom_addr_o}, 32'h0);

    // constant-ROM mixing vectors
    rom_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rom_const = vecs[i].rconst;
      gate_i    = vecs[i].gate;
      vol_i     = vecs[i].vol;
      inc_i     = '0;
      repeat (3) @(negedge clk);
      void'(model_frame());
      tick(1'b1, VOL_EN ? vecs[i].exp_vol : vecs[i].exp_plain);
      drain();
    end
    vol_i = '0;

    // single voice stepping through the table, then wrap, gate drop and hold
    rom_mode = 1'b0;
    do_reset();
    gate_i = 4'b0001;
    inc_i  = 64'h0200;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      model_tick();
      repeat (30) @(negedge clk);
    end
    drain();
    for (int k = 5; k < 129; k++) begin
      model_tick();
      repeat (14) @(negedge clk);
    end
    drain();
    model_tick();
    drain();
    gate_i = 4'b0000;
    model_tick();
    drain();
    gate_i = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      model_tick();
      repeat (14) @(negedge clk);
    end
    drain();
    inc_i = 64'h0;
    for (int k = 0; k < 2; k++) begin
      model_tick();
      repeat (14) @(negedge clk);
    end
    drain();

    // reset in the middle of a frame
    do_reset();
    gate_i = 4'b0011;
    inc_i  = {16'h0, 16'h0, 16'h0400, 16'h0200};
    model_tick();
    drain();
    model_tick();
    drain();
    repeat (3) @(negedge clk);
    n0 = nvalid;
    tick(1'b0, 16'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < NV; v++) mphase[v] = '0;
    check("midrst_busy", {31'h0, busy_o}, 32'h0);
    check("midrst_sample", {16'h0, bus.sample_o}, 32'h0);
    check("midrst_addr", {25'h0, bus.rom_addr_o}, 32'h0);
    repeat (20) @(negedge clk);
    check("midrst_no_valid", nvalid - n0, 0);
    model_tick();
    drain();

    // overrun: second tick 3 cycles after the first
    do_reset();
    n0 = nvalid;
    @(negedge clk);
    sample_tick_i = 1'b1;
    begin
      exp_t e;
      e.val  = model_frame();
      e.tcyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    sample_tick_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ovr_before", {31'h0, overrun_o}, 32'h0);
    sample_tick_i = 1'b1;
    @(negedge clk);
    sample_tick_i = 1'b0;
    check("ovr_set", {31'h0, overrun_o}, 32'h1);
    drain();
    repeat (20) @(negedge clk);
    check("ovr_one_pulse", nvalid - n0, 1);
    model_tick();
    drain();
    check("ovr_sticky", {31'h0, overrun_o}, 32'h1);
    do_reset();
    check("ovr_cleared", {31'h0, overrun_o}, 32'h0);

    // disabled ticks are ignored; dropping enable mid-frame finishes the frame
    n0 = nvalid;
    enable_i = 1'b0;
    tick(1'b0, 16'h0);
    repeat (20) @(negedge clk);
    check("dis_no_valid", nvalid - n0, 0);
    check("dis_no_overrun", {31'h0, overrun_o}, 32'h0);
    check("dis_idle", {31'h0, busy_o}, 32'h0);
    enable_i = 1'b1;
    model_tick();
    enable_i = 1'b0;
    drain();
    enable_i = 1'b1;
    check("en_drop_no_overrun", {31'h0, overrun_o}, 32'h0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
